pipeline_hazard_ctrl: RTL

Central stall/flush controller for the five-stage pipeline. It drives the hold, flush and bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers from three sources: a variable-latency data-memory handshake (FSM with timeout), the load-use interlock, and taken branches resolved in EX. It sits beside the datapath and also keeps saturating stall and flush event counters for debug.

---
 rtl/pipeline_hazard_ctrl_if.sv | 42 ++++
 rtl/pipeline_hazard_ctrl.sv | 99 +++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Control bundle between the datapath and the hazard controller.
// Master is the datapath side (drives hazard sources); slave is the controller.
interface pipeline_hazard_ctrl_if;
  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 32;

  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_re1;
  logic             id_re2;
  logic [REG_W-1:0] ex_rd;
  logic             ex_wb_ena;
  logic             ex_is_load;
  logic             ex_branch_taken;
  logic             mem_req;
  logic             dram_ready;

  logic             pc_stall;
  logic             ifid_stall;
  logic             idex_stall;
  logic             exmem_stall;
  logic             ifid_flush;
  logic             idex_flush;
  logic             memwb_bubble;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output id_rs1, id_rs2, id_re1, id_re2, ex_rd, ex_wb_ena, ex_is_load,
           ex_branch_taken, mem_req, dram_ready,
    input  pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush,
           idex_flush, memwb_bubble, mem_err, stall_cycles, flush_events
  );

  modport slave (
    input  id_rs1, id_rs2, id_re1, id_re2, ex_rd, ex_wb_ena, ex_is_load,
           ex_branch_taken, mem_req, dram_ready,
    output pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush,
           idex_flush, memwb_bubble, mem_err, stall_cycles, flush_events
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline: DRAM wait FSM with timeout,
// load-use interlock, EX branch flush, and saturating debug event counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input logic                  clk,
  input logic                  rst,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam int unsigned WAIT_W = 8;
  localparam int unsigned CNT_W  = 32;
  localparam logic [WAIT_W-1:0] TIMEOUT_W = WAIT_W'(TIMEOUT);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]    stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0]    flush_events_q, flush_events_d;

  logic mem_stall_c;
  logic mem_err_c;
  logic load_use_c;
  logic branch_c;
  logic pc_stall_c;
  logic ifid_flush_c;

  // DRAM wait FSM; wait_cnt counts MEM_WAIT cycles of the current access
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = '0;
    mem_stall_c = 1'b0;
    mem_err_c   = 1'b0;
    case (state_q)
      RUN: begin
        if (hz.mem_req && !hz.dram_ready) begin
          mem_stall_c = 1'b1;
          state_d     = MEM_WAIT;
          wait_cnt_d  = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (hz.dram_ready) begin
          state_d = RUN;
        end else if (wait_cnt_q == TIMEOUT_W) begin
          mem_err_c = 1'b1;
          state_d   = RUN;
        end else begin
          mem_stall_c = 1'b1;
          wait_cnt_d  = wait_cnt_q + WAIT_W'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Priority: memory stall freezes everything, then branch flush, then load-use
  always_comb begin
    branch_c   = !mem_stall_c && hz.ex_branch_taken;
    load_use_c = !mem_stall_c && !hz.ex_branch_taken &&
                 hz.ex_is_load && hz.ex_wb_ena && (hz.ex_rd != '0) &&
                 ((hz.id_re1 && (hz.id_rs1 == hz.ex_rd)) ||
                  (hz.id_re2 && (hz.id_rs2 == hz.ex_rd)));
    pc_stall_c   = mem_stall_c || load_use_c;
    ifid_flush_c = branch_c;
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (pc_stall_c && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + CNT_W'(1);
    if (ifid_flush_c && (flush_events_q != '1)) flush_events_d = flush_events_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= RUN;
      wait_cnt_q     <= '0;
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign hz.pc_stall     = pc_stall_c;
  assign hz.ifid_stall   = pc_stall_c;
  assign hz.idex_stall   = mem_stall_c;
  assign hz.exmem_stall  = mem_stall_c;
  assign hz.ifid_flush   = ifid_flush_c;
  assign hz.idex_flush   = branch_c || load_use_c;
  assign hz.memwb_bubble = mem_stall_c;
  assign hz.mem_err      = mem_err_c;
  assign hz.stall_cycles = stall_cycles_q;
  assign hz.flush_events = flush_events_q;
endmodule
